// File: rtl/stage_4_pkg.sv
// Shared definitions for the CORDIC final summing stage: state encodings,
// default adder latency and FP32 constants/classification helpers.
package stage_4_pkg;

  localparam int STATE_WIDTH         = 2;
  localparam int ADD_LATENCY_DEFAULT = 4;

  localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] EXP_MASK = 32'h7F80_0000;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE     = 2'd0,
    ADD_AB   = 2'd1,
    ADD_BIAS = 2'd2,
    DONE     = 2'd3
  } state_t;

  function automatic logic fp_is_nan(input logic [31:0] v);
    return ((v & EXP_MASK) == EXP_MASK) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] v);
    return ((v & EXP_MASK) == EXP_MASK) && (v[22:0] == 23'd0);
  endfunction

endpackage

// File: rtl/fp_add.sv
// Pipelined IEEE-754 single-precision adder, round-to-nearest-even.
// The sum of the operands appears LATENCY enabled cycles after they are presented.
module fp_add
  import stage_4_pkg::*;
#(
  parameter int LATENCY = ADD_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  function automatic logic [31:0] fp32_add(input logic [31:0] p, input logic [31:0] q);
    logic [31:0] x, y;
    logic [26:0] mx, my, m;
    logic [27:0] s;
    logic [24:0] mr;
    logic        rnd;
    logic [7:0]  ef;
    int          ex, ey, e, d;
    if (fp_is_nan(p) || fp_is_nan(q)) return FP_QNAN;
    if (fp_is_inf(p) && fp_is_inf(q) && (p[31] != q[31])) return FP_QNAN;
    if (fp_is_inf(p)) return p;
    if (fp_is_inf(q)) return q;
    x = p;
    y = q;
    if (q[30:0] > p[30:0]) begin
      x = q;
      y = p;
    end
    ex = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    ey = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
    mx = {(x[30:23] != 8'd0), x[22:0], 3'b000};
    my = {(y[30:23] != 8'd0), y[22:0], 3'b000};
    d  = ex - ey;
    // Bits shifted out of the smaller operand collapse into the sticky bit.
    if (d >= 27) my = {26'd0, |my};
    else         my = (my >> d) | {26'd0, |(my & ((27'd1 << d) - 27'd1))};
    e = ex;
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, my};
      if (s[27]) begin
        m = s[27:1] | {26'd0, s[0]};
        e = e + 1;
      end else begin
        m = s[26:0];
      end
    end else begin
      m = mx - my;
      if (m == 27'd0) return FP_ZERO;
      for (int i = 0; i < 26; i++) begin
        if (!m[26] && (e > 1)) begin
          m = m << 1;
          e = e - 1;
        end
      end
    end
    rnd = m[2] && (m[1] || m[0] || m[3]);
    mr  = {1'b0, m[26:3]} + {24'd0, rnd};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 1;
    end
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    ef = mr[23] ? e[7:0] : 8'd0;
    return {x[31], ef, mr[22:0]};
  endfunction

  logic [31:0] pipe [LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= FP_ZERO;
    end else if (en) begin
      pipe[0] <= fp32_add(a, b);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign sum = pipe[LATENCY-1];

endmodule

// File: rtl/stage_4_timer.sv
// add_latency_timer: counts 0..LATENCY-1 while enabled, then raises a
// registered terminal-count flag that holds until the next load.
module add_latency_timer
  import stage_4_pkg::*;
#(
  parameter int LATENCY = ADD_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [3:0] LAST = 4'(LATENCY - 1);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= 4'd0;
      tc    <= 1'b0;
    end else if (en) begin
      if (count == LAST) tc    <= 1'b1;
      else               count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/stage_4.sv
// Final CORDIC summing stage: result = (add_one + add_two) + bias using one shared
// pipelined fp_add over two passes. STAGE_4_STATUS_EN adds a NaN/Inf status output.
module stage_4
  import stage_4_pkg::*;
#(
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int ADD_LATENCY      = ADD_LATENCY_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        start,
  input  logic [FLOAT_DATA_WIDTH-1:0] add_one,
  input  logic [FLOAT_DATA_WIDTH-1:0] add_two,
  input  logic [FLOAT_DATA_WIDTH-1:0] bias,
  output logic [FLOAT_DATA_WIDTH-1:0] result,
  output logic                        done,
  output logic                        busy
`ifdef STAGE_4_STATUS_EN
  ,
  output logic [1:0]                  status
`endif
);

  state_t                      state, state_next;
  logic [FLOAT_DATA_WIDTH-1:0] add_one_q, add_two_q, bias_q, partial;
  logic [FLOAT_DATA_WIDTH-1:0] op_a, op_b, adder_sum;
  logic                        tc, timer_load;
  logic                        accept, ab_finish, bias_finish;

  assign accept      = clk_en && (state == IDLE) && start;
  assign ab_finish   = clk_en && (state == ADD_AB) && tc;
  assign bias_finish = clk_en && (state == ADD_BIAS) && tc;
  assign timer_load  = clk_en && ((state == IDLE) || (state == DONE) || tc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE:     if (accept) state_next = ADD_AB;
      ADD_AB: begin
        busy = 1'b1;
        if (ab_finish) state_next = ADD_BIAS;
      end
      ADD_BIAS: begin
        busy = 1'b1;
        if (bias_finish) state_next = DONE;
      end
      DONE: begin
        done = clk_en;
        if (clk_en) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Operand select depends only on state, so the pipeline never mixes passes.
  always_comb begin
    op_a = add_one_q;
    op_b = add_two_q;
    if (state == ADD_BIAS) begin
      op_a = partial;
      op_b = bias_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_one_q <= FP_ZERO;
      add_two_q <= FP_ZERO;
      bias_q    <= FP_ZERO;
      partial   <= FP_ZERO;
      result    <= FP_ZERO;
    end else begin
      if (accept) begin
        add_one_q <= add_one;
        add_two_q <= add_two;
        bias_q    <= bias;
      end
      if (ab_finish)   partial <= adder_sum;
      if (bias_finish) result  <= adder_sum;
    end
  end

`ifdef STAGE_4_STATUS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             status <= 2'b00;
    else if (bias_finish) status <= {fp_is_inf(adder_sum), fp_is_nan(adder_sum)};
  end
`endif

  add_latency_timer #(.LATENCY(ADD_LATENCY)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (clk_en),
    .tc   (tc)
  );

  fp_add #(.LATENCY(ADD_LATENCY)) u_fp_add (
    .clk (clk),
    .rst (rst),
    .en  (clk_en),
    .a   (op_a),
    .b   (op_b),
    .sum (adder_sum)
  );

endmodule
